prog_clk_gen: RTL

PROG_CLK_GEN -- requirements
Module: prog_clk_gen

---
 rtl/prog_clk_gen_if.sv | 40 ++++
 rtl/prog_clk_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_gen_if.sv
// prog_clk_gen_if
// Configuration handshake for prog_clk_gen. A master offers a new period,
// high time and mode with i_cfg_valid. The generator reports whether it can
// take an offer (o_cfg_ready) and pulses o_cfg_err when it rejects one.
//
// Signals:
//   i_cfg_valid  master -> gen  config offer
//   i_cfg_div    master -> gen  period P in generator clock cycles
//   i_cfg_high   master -> gen  high time H (mode 01 only)
//   i_cfg_mode   master -> gen  00 50% duty, 01 programmable, 10 pulse, 11 reserved
//   o_cfg_ready  gen -> master  no config waiting to be applied
//   o_cfg_err    gen -> master  one-cycle strobe on a rejected offer
interface prog_clk_gen_if #(
  parameter int CNT_W = 32
);
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [CNT_W-1:0] i_cfg_div;
  logic [CNT_W-1:0] i_cfg_high;
  logic [1:0]       i_cfg_mode;
  logic             o_cfg_err;

  modport master (
    output i_cfg_valid,
    output i_cfg_div,
    output i_cfg_high,
    output i_cfg_mode,
    input  o_cfg_ready,
    input  o_cfg_err
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_div,
    input  i_cfg_high,
    input  i_cfg_mode,
    output o_cfg_ready,
    output o_cfg_err
  );
endinterface

// File: rtl/prog_clk_gen.sv
// prog_clk_gen
// Programmable clock divider. Produces a registered divided clock o_clk and a
// period-start strobe o_tick. The period and high time come from an active
// configuration. A new configuration is staged in a shadow register and
// swapped in only at a period boundary, so a running waveform never sees a
// truncated or stretched period.
//
// Ports:
//   i_clk    input   generator clock, rising edge
//   i_reset  input   synchronous, active-high reset
//   i_en     input   run enable; low stops and clears the waveform at once
//   cfg_if   slave   configuration handshake (see prog_clk_gen_if)
//   o_clk    output  divided clock, high for cnt < Hact
//   o_tick   output  one-cycle strobe at cnt == 0
//
// state   | meaning
// ST_IDLE | not running, outputs low, cnt held at 0; a pending config is applied
// ST_RUN  | counting 0..P-1; a pending config is applied at the wrap to 0
module prog_clk_gen #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 500_000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  prog_clk_gen_if.slave cfg_if,
  output logic          o_clk,
  output logic          o_tick
);

  localparam logic [CNT_W-1:0] DEF_P    = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HACT = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  // Active config. Mode is not kept separately: it only shapes Hact, which
  // is resolved once when the offer is accepted.
  logic [CNT_W-1:0] r_p;
  logic [CNT_W-1:0] r_hact;
  logic [CNT_W-1:0] r_sh_p;
  logic [CNT_W-1:0] r_sh_hact;
  logic             r_pending;
  logic             r_clk;
  logic             r_tick;
  logic             r_err;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_p_nx;
  logic [CNT_W-1:0] w_hact_nx;
  logic [CNT_W-1:0] w_sh_p_nx;
  logic [CNT_W-1:0] w_sh_hact_nx;
  logic             w_pending_nx;
  logic             w_clk_nx;
  logic             w_tick_nx;
  logic             w_err_nx;
  logic             w_run_nx;
  logic             w_apply;
  logic             w_wrap;
  logic             w_accept;
  logic             w_cfg_bad;
  logic [CNT_W-1:0] w_cfg_hact;

  // Offers are only looked at while nothing is waiting in the shadow, so a
  // staged config can never be overwritten before it takes effect.
  assign w_accept = cfg_if.i_cfg_valid & ~r_pending;

  assign w_cfg_bad = (cfg_if.i_cfg_div < TWO)
                   | (cfg_if.i_cfg_mode == 2'b11)
                   | ((cfg_if.i_cfg_mode == 2'b01)
                      & ((cfg_if.i_cfg_high == '0)
                         | (cfg_if.i_cfg_high >= cfg_if.i_cfg_div)));

  always_comb begin
    w_cfg_hact = ONE;
    case (cfg_if.i_cfg_mode)
      2'b00:   w_cfg_hact = cfg_if.i_cfg_div >> 1;
      2'b01:   w_cfg_hact = cfg_if.i_cfg_high;
      default: w_cfg_hact = ONE;
    endcase
  end

  // cnt never exceeds P-1 because P only changes at a wrap or while idle,
  // both of which leave cnt at 0.
  assign w_wrap = (r_cnt == (r_p - ONE));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    w_apply    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Idle: a staged config goes live immediately, so when this same
        // edge starts running the first period already uses it.
        w_apply = r_pending;
        if (i_en) begin
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_en) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = w_wrap ? '0 : (r_cnt + ONE);
          w_apply  = r_pending & w_wrap;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    w_run_nx  = (w_state_nx == ST_RUN);
    w_p_nx    = w_apply ? r_sh_p    : r_p;
    w_hact_nx = w_apply ? r_sh_hact : r_hact;

    // Outputs are registered from the next-state values, so the new config
    // shapes the very first cycle of the period it starts.
    w_clk_nx  = w_run_nx & (w_cnt_nx < w_hact_nx);
    w_tick_nx = w_run_nx & (w_cnt_nx == '0);

    w_sh_p_nx    = r_sh_p;
    w_sh_hact_nx = r_sh_hact;
    w_pending_nx = r_pending;
    w_err_nx     = 1'b0;

    if (w_apply) begin
      w_pending_nx = 1'b0;
    end

    // Acceptance needs r_pending low and apply needs it high, so the two
    // never collide on one edge. A config accepted on a wrap edge is only
    // visible as pending afterwards and waits for the next wrap.
    if (w_accept) begin
      if (w_cfg_bad) begin
        w_err_nx = 1'b1;
      end else begin
        w_sh_p_nx    = cfg_if.i_cfg_div;
        w_sh_hact_nx = w_cfg_hact;
        w_pending_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_p       <= DEF_P;
      r_hact    <= DEF_HACT;
      r_sh_p    <= DEF_P;
      r_sh_hact <= DEF_HACT;
      r_pending <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_p       <= w_p_nx;
      r_hact    <= w_hact_nx;
      r_sh_p    <= w_sh_p_nx;
      r_sh_hact <= w_sh_hact_nx;
      r_pending <= w_pending_nx;
      r_clk     <= w_clk_nx;
      r_tick    <= w_tick_nx;
      r_err     <= w_err_nx;
    end
  end

  assign o_clk              = r_clk;
  assign o_tick             = r_tick;
  assign cfg_if.o_cfg_ready = ~r_pending;
  assign cfg_if.o_cfg_err   = r_err;

endmodule
